// File: rtl/datapath_pkg.sv
// Shared mux/ALU select codes for the operative block and its controller.
// Both sides import this so encodings never drift apart.
package datapath_pkg;

    localparam logic [1:0] A_RX   = 2'b00;
    localparam logic [1:0] A_RH   = 2'b01;
    localparam logic [1:0] A_RS   = 2'b10;
    localparam logic [1:0] A_ZERO = 2'b11;

    localparam logic [1:0] B_RX   = 2'b00;
    localparam logic [1:0] B_XIN  = 2'b01;
    localparam logic [1:0] B_RH   = 2'b10;
    localparam logic [1:0] B_K    = 2'b11;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

endpackage

// File: rtl/alu_w.sv
// Combinational W-bit unsigned ALU: add, subtract, multiply, pass.
// ovf flags carry-out, borrow, or a nonzero high product half.
module alu_w
    import datapath_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [1:0]   op,
    output logic [W-1:0] Y,
    output logic         ovf
);

    logic [W:0]     sum;
    logic [W:0]     dif;
    logic [2*W-1:0] prod;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign dif  = {1'b0, A} - {1'b0, B};
    assign prod = A * B;

    // Select result and overflow condition for the requested operation
    always_comb begin
        Y   = A;
        ovf = 1'b0;
        unique case (op)
            OP_ADD: begin
                Y   = sum[W-1:0];
                ovf = sum[W];
            end
            OP_SUB: begin
                Y   = dif[W-1:0];
                ovf = dif[W];
            end
            OP_MUL: begin
                Y   = prod[W-1:0];
                ovf = |prod[2*W-1:W];
            end
            OP_PASS: begin
                Y   = A;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bloco_operativo_ctrl_resp.sv
// Operative block: RX/RH/RS registers around a shared ALU, sticky
// overflow, and a rising-edge detector on finished that captures RS.
module bloco_operativo_ctrl_resp
    import datapath_pkg::*;
#(
    parameter int W = 8,
    parameter int K = 3
) (
    input  logic         clk,
    input  logic         RST,
    input  logic [W-1:0] X_in,
    input  logic         LX,
    input  logic         LH,
    input  logic         LS,
    input  logic         H,
    input  logic [1:0]   M0,
    input  logic [1:0]   M1,
    input  logic [1:0]   M2,
    input  logic         finished,
    output logic [W-1:0] result,
    output logic         done,
    output logic         ovf,
    output logic [W-1:0] acc
);

    localparam logic [W-1:0] KW = W'(K);

    logic [W-1:0] rx;
    logic [W-1:0] rh;
    logic [W-1:0] rs;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] alu_y;
    logic         alu_ovf;
    logic         fin_d;
    logic         fin_rise;

    assign acc      = rs;
    assign fin_rise = finished & ~fin_d;

    // Operand A mux
    always_comb begin
        op_a = '0;
        unique case (M0)
            A_RX:   op_a = rx;
            A_RH:   op_a = rh;
            A_RS:   op_a = rs;
            A_ZERO: op_a = '0;
        endcase
    end

    // Operand B mux
    always_comb begin
        op_b = '0;
        unique case (M1)
            B_RX:  op_b = rx;
            B_XIN: op_b = X_in;
            B_RH:  op_b = rh;
            B_K:   op_b = KW;
        endcase
    end

    alu_w #(.W(W)) u_alu (
        .A   (op_a),
        .B   (op_b),
        .op  (M2),
        .Y   (alu_y),
        .ovf (alu_ovf)
    );

    // Datapath registers; all loads sample pre-edge values
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            rx <= '0;
            rh <= '0;
            rs <= '0;
        end else begin
            if (LX) rx <= op_b;
            if (LH) rh <= H ? alu_y : rs;
            if (LS) rs <= alu_y;
        end
    end

    // Sticky overflow; a new operation (LX) clears it with priority
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            ovf <= 1'b0;
        end else if (LX) begin
            ovf <= 1'b0;
        end else if ((LS | (LH & H)) & alu_ovf) begin
            ovf <= 1'b1;
        end
    end

    // Completion edge detector: capture RS and pulse done once
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            fin_d  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            fin_d <= finished;
            done  <= fin_rise;
            if (fin_rise) result <= rs;
        end
    end

endmodule

// File: tb/tb_bloco_operativo_ctrl_resp.sv
// Self-checking bench: directed scenarios plus random strobes
// compared against an arithmetic reference model.
module tb_bloco_operativo_ctrl_resp;

    localparam int W = 8;
    localparam int K = 3;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         RST;
    logic [W-1:0] X_in;
    logic         LX, LH, LS, H;
    logic [1:0]   M0, M1, M2;
    logic         finished;
    logic [W-1:0] result;
    logic         done;
    logic         ovf;
    logic [W-1:0] acc;

    int nchk = 0;
    int nerr = 0;

    int m_rx, m_rh, m_rs, m_res, m_done, m_ovf, m_fd;

    bloco_operativo_ctrl_resp #(.W(W), .K(K)) dut (
        .clk      (clk),
        .RST      (RST),
        .X_in     (X_in),
        .LX       (LX),
        .LH       (LH),
        .LS       (LS),
        .H        (H),
        .M0       (M0),
        .M1       (M1),
        .M2       (M2),
        .finished (finished),
        .result   (result),
        .done     (done),
        .ovf      (ovf),
        .acc      (acc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void alu_ref(input int a, input int b, input int op,
                                    output int y, output int ov);
        int r;
        case (op)
            0: begin r = a + b; ov = (r >= MOD) ? 1 : 0; end
            1: begin r = a - b; ov = (a < b) ? 1 : 0; end
            2: begin r = a * b; ov = (r >= MOD) ? 1 : 0; end
            default: begin r = a; ov = 0; end
        endcase
        y = ((r % MOD) + MOD) % MOD;
    endfunction

    task automatic model_reset();
        m_rx = 0; m_rh = 0; m_rs = 0;
        m_res = 0; m_done = 0; m_ovf = 0; m_fd = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rx"}, int'(dut.rx), m_rx);
        check({tag, ".rh"}, int'(dut.rh), m_rh);
        check({tag, ".acc"}, int'(acc), m_rs);
        check({tag, ".result"}, int'(result), m_res);
        check({tag, ".done"}, int'(done), m_done);
        check({tag, ".ovf"}, int'(ovf), m_ovf);
    endtask

    task automatic cycle(input string tag, input bit lx, input bit lh,
                         input bit ls, input bit hh, input int m0,
                         input int m1, input int m2, input int x,
                         input bit fin);
        int a, b, y, ov;
        int n_rx, n_rh, n_rs, n_res, n_done, n_ovf;
        LX = lx; LH = lh; LS = ls; H = hh;
        M0 = 2'(m0); M1 = 2'(m1); M2 = 2'(m2);
        X_in = W'(x); finished = fin;
        a = (m0 == 0) ? m_rx : (m0 == 1) ? m_rh : (m0 == 2) ? m_rs : 0;
        b = (m1 == 0) ? m_rx : (m1 == 1) ? x : (m1 == 2) ? m_rh : K % MOD;
        alu_ref(a, b, m2, y, ov);
        n_rx  = lx ? b : m_rx;
        n_rh  = lh ? (hh ? y : m_rs) : m_rh;
        n_rs  = ls ? y : m_rs;
        n_ovf = lx ? 0 : (((ls || (lh && hh)) && ov) ? 1 : m_ovf);
        n_done = (fin && !m_fd) ? 1 : 0;
        n_res  = n_done ? m_rs : m_res;
        @(posedge clk);
        #1;
        m_rx = n_rx; m_rh = n_rh; m_rs = n_rs; m_ovf = n_ovf;
        m_done = n_done; m_res = n_res; m_fd = fin;
        check_all(tag);
    endtask

    initial begin
        int dsum;
        RST = 1'b0;
        {LX, LH, LS, H, finished} = '0;
        M0 = '0; M1 = '0; M2 = '0; X_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        RST = 1'b1;

        cycle("t2_ldx", 1, 0, 0, 0, 0, 1, 0, 5, 0);
        check("t2_rx5", int'(dut.rx), 5);
        cycle("t2_add", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("t2_rs10", int'(acc), 10);
        check("t2_ovf0", int'(ovf), 0);

        cycle("t3_ldx", 1, 0, 0, 0, 0, 1, 0, 20, 0);
        cycle("t3_mul", 0, 0, 1, 0, 0, 0, 2, 0, 0);
        check("t3_rs90", int'(acc), 'h90);
        check("t3_ovf1", int'(ovf), 1);
        cycle("t3_clr", 1, 0, 0, 0, 0, 1, 0, 1, 0);
        check("t3_ovf0", int'(ovf), 0);

        cycle("t4_ldx", 1, 0, 0, 0, 0, 1, 0, 7, 0);
        cycle("t4_rs", 0, 0, 1, 0, 0, 0, 3, 0, 0);
        cycle("t4_h0", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("t4_rh7", int'(dut.rh), 7);
        cycle("t4_h1", 0, 1, 0, 1, 3, 3, 0, 0, 0);
        check("t4_rh3", int'(dut.rh), 3);

        cycle("t5_ldx4", 1, 0, 0, 0, 0, 1, 0, 4, 0);
        cycle("t5_rs4", 0, 0, 1, 0, 0, 0, 3, 0, 0);
        cycle("t5_ldx9", 1, 0, 0, 0, 0, 1, 0, 9, 0);
        cycle("t5_rh9", 0, 1, 0, 1, 0, 0, 3, 0, 0);
        cycle("t5_sim", 0, 1, 1, 0, 1, 3, 0, 0, 0);
        check("t5_rh4", int'(dut.rh), 4);
        check("t5_rs12", int'(acc), 12);

        cycle("t6_ldx", 1, 0, 0, 0, 0, 1, 0, 42, 0);
        cycle("t6_rs", 0, 0, 1, 0, 0, 0, 3, 0, 0);
        dsum = 0;
        for (int i = 0; i < 3; i++) begin
            cycle("t6_fin", 0, 0, 0, 0, 0, 0, 0, 0, 1);
            dsum += int'(done);
            check("t6_res42", int'(result), 42);
        end
        check("t6_one_pulse", dsum, 1);
        cycle("t6_drop", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t6_done_lo", int'(done), 0);
        cycle("t6_rise2", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("t6_done2", int'(done), 1);

        for (int i = 0; i < 400; i++) begin
            cycle("rnd",
                  bit'($urandom_range(0, 3) == 0),
                  bit'($urandom_range(0, 2) == 0),
                  bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, MOD - 1)),
                  bit'($urandom_range(0, 3) != 0));
        end

        cycle("t1_ldx", 1, 0, 0, 0, 0, 1, 0, 200, 0);
        cycle("t1_rs", 0, 1, 1, 1, 0, 0, 2, 0, 0);
        cycle("t1_fin", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("t1_ovf_pre", int'(ovf), 1);
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check_all("t1_async");

        LX = 0; LH = 0; LS = 0; finished = 1'b1;
        @(posedge clk);
        #1;
        check("t1_hold_done", int'(done), 0);
        RST = 1'b1;
        cycle("t1_rel", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("t1_rel_done", int'(done), 1);
        cycle("t1_rel2", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("t1_rel_done2", int'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
